// File: rtl/regfile_pkg.sv
// Shared register-file constants and types used by decode, writeback and
// the scoreboard itself.
package regfile_pkg;
  localparam int DEF_XLEN     = 32;
  localparam int DEF_NREGS    = 32;
  localparam int DEF_MAX_PEND = 3;
  localparam int DEF_CW       = $clog2(DEF_MAX_PEND + 1);

  // x0 is hardwired zero: never written, never tracked.
  localparam int REG_ZERO = 0;

  typedef logic [DEF_CW-1:0] pend_cnt_t;
endpackage

// File: rtl/regfile_scoreboard_pend_counter.sv
// Saturating up/down counter tracking outstanding writes to one register.
// A decrement is only honoured when the count is nonzero; an increment is
// only honoured below MAX_PEND unless a decrement lands in the same cycle.
module pend_counter #(
  parameter int MAX_PEND = 3,
  parameter int CW       = $clog2(MAX_PEND + 1)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          inc,
  input  logic          dec,
  input  logic          clr,
  output logic [CW-1:0] cnt,
  output logic          nonzero,
  output logic          full
);
  logic inc_eff, dec_eff;

  assign nonzero = (cnt != '0);
  assign full    = (cnt == CW'(MAX_PEND));
  assign dec_eff = dec && nonzero;
  assign inc_eff = inc && (!full || dec_eff);

  // Count update; clear wins over any concurrent inc/dec.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)                     cnt <= '0;
    else if (clr)                   cnt <= '0;
    else if (inc_eff && !dec_eff)   cnt <= cnt + 1'b1;
    else if (dec_eff && !inc_eff)   cnt <= cnt - 1'b1;
  end
endmodule

// File: rtl/regfile_scoreboard.sv
// Integer register file with two combinational read ports, one write port,
// optional writeback-to-read bypass and a per-register pending-write
// scoreboard that drives the decode stall.
module regfile_scoreboard
  import regfile_pkg::*;
#(
  parameter int XLEN     = DEF_XLEN,
  parameter int NREGS    = DEF_NREGS,
  parameter int MAX_PEND = DEF_MAX_PEND,
  parameter int BYPASS   = 1,
  localparam int AW      = $clog2(NREGS),
  localparam int CW      = $clog2(MAX_PEND + 1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [AW-1:0]    rs1,
  input  logic [AW-1:0]    rs2,
  input  logic             use_rs1,
  input  logic             use_rs2,
  output logic [XLEN-1:0]  rd1_data,
  output logic [XLEN-1:0]  rd2_data,
  output logic             rs1_busy,
  output logic             rs2_busy,
  output logic             hazard,
  input  logic             issue_valid,
  input  logic [AW-1:0]    issue_rd,
  output logic             issue_ready,
  input  logic             wb_valid,
  input  logic [AW-1:0]    wb_rd,
  input  logic [XLEN-1:0]  wb_data,
  input  logic             flush,
  output logic [NREGS-1:0] busy_vec,
  output logic             wb_err
);
  localparam logic [AW-1:0] ZERO = AW'(REG_ZERO);

  logic [NREGS-1:0][XLEN-1:0] regs;
  logic [NREGS-1:0][CW-1:0]   cnt;
  logic [NREGS-1:0]           nz;
  logic [NREGS-1:0]           full;

  logic wb_we, issue_fire, wb_err_nxt;

  assign wb_we      = wb_valid && (wb_rd != ZERO);
  // A writeback to the same register frees a slot this cycle, so a full
  // counter can still accept the issue.
  assign issue_ready = !(full[issue_rd] && !(wb_valid && wb_rd == issue_rd));
  assign issue_fire  = issue_valid && issue_ready && (issue_rd != ZERO);

  // x0 has no counter.
  assign cnt[0]  = '0;
  assign nz[0]   = 1'b0;
  assign full[0] = 1'b0;

  for (genvar i = 1; i < NREGS; i++) begin : g_cnt
    pend_counter #(.MAX_PEND(MAX_PEND), .CW(CW)) u_cnt (
      .clk     (clk),
      .reset   (reset),
      .inc     (issue_fire && (issue_rd == AW'(i))),
      .dec     (wb_valid && (wb_rd == AW'(i))),
      .clr     (flush),
      .cnt     (cnt[i]),
      .nonzero (nz[i]),
      .full    (full[i])
    );
  end

  assign busy_vec = nz;

  // Register storage; x0 is never written so it stays zero.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)     regs <= '0;
    else if (wb_we) regs[wb_rd] <= wb_data;
  end

  // Writeback with nothing outstanding (and no same-cycle issue) is flagged
  // for one cycle; flush does not suppress it.
  assign wb_err_nxt = wb_we && !nz[wb_rd] && !(issue_fire && issue_rd == wb_rd);

  // One-cycle error pulse.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) wb_err <= 1'b0;
    else        wb_err <= wb_err_nxt;
  end

  // Read ports with optional forwarding of this cycle's writeback.
  always_comb begin
    rd1_data = '0;
    rd2_data = '0;
    if (rs1 != ZERO) begin
      if (BYPASS != 0 && wb_valid && wb_rd == rs1) rd1_data = wb_data;
      else                                         rd1_data = regs[rs1];
    end
    if (rs2 != ZERO) begin
      if (BYPASS != 0 && wb_valid && wb_rd == rs2) rd2_data = wb_data;
      else                                         rd2_data = regs[rs2];
    end
  end

  // Busy uses the pre-issue count; with bypass, the last outstanding write
  // arriving this cycle is forwarded and does not stall.
  always_comb begin
    rs1_busy = nz[rs1];
    rs2_busy = nz[rs2];
    if (BYPASS != 0 && cnt[rs1] == CW'(1) && wb_valid && wb_rd == rs1) rs1_busy = 1'b0;
    if (BYPASS != 0 && cnt[rs2] == CW'(1) && wb_valid && wb_rd == rs2) rs2_busy = 1'b0;
  end

  assign hazard = (use_rs1 && rs1_busy) || (use_rs2 && rs2_busy);
endmodule

// File: tb/tb_regfile_scoreboard.sv
// Randomised + directed scoreboard bench: two DUTs (bypass on/off) share
// stimulus; a reference model predicts outputs per cycle into a queue and a
// monitor pops and compares on the falling edge.
module tb_regfile_scoreboard;
  localparam int XLEN = 32, NREGS = 32, AW = 5, MAXP = 3;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic            reset, use_rs1, use_rs2, issue_valid, wb_valid, flush;
  logic [AW-1:0]   rs1, rs2, issue_rd, wb_rd;
  logic [XLEN-1:0] wb_data;

  logic [1:0][XLEN-1:0] rd1, rd2;
  logic [1:0]           b1, b2, hz, rdy, err;
  logic [1:0][NREGS-1:0] bv;

  regfile_scoreboard #(.BYPASS(0)) u_nb (
    .clk(clk), .reset(reset), .rs1(rs1), .rs2(rs2), .use_rs1(use_rs1), .use_rs2(use_rs2),
    .rd1_data(rd1[0]), .rd2_data(rd2[0]), .rs1_busy(b1[0]), .rs2_busy(b2[0]), .hazard(hz[0]),
    .issue_valid(issue_valid), .issue_rd(issue_rd), .issue_ready(rdy[0]),
    .wb_valid(wb_valid), .wb_rd(wb_rd), .wb_data(wb_data), .flush(flush),
    .busy_vec(bv[0]), .wb_err(err[0]));

  regfile_scoreboard #(.BYPASS(1)) u_bp (
    .clk(clk), .reset(reset), .rs1(rs1), .rs2(rs2), .use_rs1(use_rs1), .use_rs2(use_rs2),
    .rd1_data(rd1[1]), .rd2_data(rd2[1]), .rs1_busy(b1[1]), .rs2_busy(b2[1]), .hazard(hz[1]),
    .issue_valid(issue_valid), .issue_rd(issue_rd), .issue_ready(rdy[1]),
    .wb_valid(wb_valid), .wb_rd(wb_rd), .wb_data(wb_data), .flush(flush),
    .busy_vec(bv[1]), .wb_err(err[1]));

  typedef struct {
    bit rstn; int r1; int r2; bit u1; bit u2;
    bit iv; int ird; bit wv; int wrd; logic [31:0] wd; bit fl;
  } stim_t;

  typedef struct {
    logic [1:0][31:0] rd1, rd2;
    logic [1:0] b1, b2, hz;
    logic rdy, err;
    logic [31:0] bv;
  } exp_t;

  exp_t q[$];
  int tests = 0, fails = 0, cyc = 0;

  // Reference model: architectural state only.
  logic [31:0] mregs [NREGS];
  int          mcnt  [NREGS];
  bit          merr;

  function automatic void model_reset();
    for (int i = 0; i < NREGS; i++) begin mregs[i] = '0; mcnt[i] = 0; end
    merr = 1'b0;
  endfunction

  function automatic bit m_ready(stim_t s);
    return !(mcnt[s.ird] == MAXP && !(s.wv && s.wrd == s.ird));
  endfunction

  function automatic logic [31:0] m_read(stim_t s, int rs, bit bp);
    if (rs == 0) return '0;
    if (bp && s.wv && s.wrd == rs) return s.wd;
    return mregs[rs];
  endfunction

  function automatic bit m_busy(stim_t s, int rs, bit bp);
    if (rs == 0 || mcnt[rs] == 0) return 1'b0;
    if (bp && mcnt[rs] == 1 && s.wv && s.wrd == rs) return 1'b0;
    return 1'b1;
  endfunction

  function automatic exp_t model_expect(stim_t s);
    exp_t e;
    for (int b = 0; b < 2; b++) begin
      e.rd1[b] = m_read(s, s.r1, b[0]);
      e.rd2[b] = m_read(s, s.r2, b[0]);
      e.b1[b]  = m_busy(s, s.r1, b[0]);
      e.b2[b]  = m_busy(s, s.r2, b[0]);
      e.hz[b]  = (s.u1 && e.b1[b]) || (s.u2 && e.b2[b]);
    end
    e.rdy = m_ready(s);
    e.err = merr;
    for (int i = 0; i < NREGS; i++) e.bv[i] = (mcnt[i] != 0);
    return e;
  endfunction

  function automatic void model_clock(stim_t s);
    bit fire;
    fire = s.iv && m_ready(s) && s.ird != 0;
    merr = s.wv && s.wrd != 0 && mcnt[s.wrd] == 0 && !(fire && s.ird == s.wrd);
    for (int r = 1; r < NREGS; r++) begin
      bit inc, dec;
      inc = fire && s.ird == r;
      dec = s.wv && s.wrd == r && mcnt[r] != 0;
      if (s.fl)             mcnt[r] = 0;
      else if (inc && !dec) mcnt[r] = mcnt[r] + 1;
      else if (dec && !inc) mcnt[r] = mcnt[r] - 1;
    end
    if (s.wv && s.wrd != 0) mregs[s.wrd] = s.wd;
  endfunction

  function automatic stim_t idle();
    stim_t s;
    s.rstn = 1'b1; s.r1 = 0; s.r2 = 0; s.u1 = 1'b0; s.u2 = 1'b0;
    s.iv = 1'b0; s.ird = 0; s.wv = 1'b0; s.wrd = 0; s.wd = '0; s.fl = 1'b0;
    return s;
  endfunction

  // Called at posedge+1: drive, predict, then advance the model at the edge.
  task automatic step(input stim_t s);
    reset = s.rstn; rs1 = AW'(s.r1); rs2 = AW'(s.r2); use_rs1 = s.u1; use_rs2 = s.u2;
    issue_valid = s.iv; issue_rd = AW'(s.ird); wb_valid = s.wv; wb_rd = AW'(s.wrd);
    wb_data = s.wd; flush = s.fl;
    if (!s.rstn) model_reset();
    q.push_back(model_expect(s));
    @(posedge clk);
    if (s.rstn) model_clock(s); else model_reset();
    #1;
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s cyc=%0d got=%h exp=%h", nm, cyc, act, exp);
    end
  endtask

  // Monitor: every cycle the DUTs present a response; compare it.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      cyc++;
      if (q.size() != 0) begin
        e = q.pop_front();
        for (int b = 0; b < 2; b++) begin
          chk($sformatf("rd1_data[bp%0d]", b), rd1[b], e.rd1[b]);
          chk($sformatf("rd2_data[bp%0d]", b), rd2[b], e.rd2[b]);
          chk($sformatf("rs1_busy[bp%0d]", b), 32'(b1[b]), 32'(e.b1[b]));
          chk($sformatf("rs2_busy[bp%0d]", b), 32'(b2[b]), 32'(e.b2[b]));
          chk($sformatf("hazard[bp%0d]", b), 32'(hz[b]), 32'(e.hz[b]));
          chk($sformatf("issue_ready[bp%0d]", b), 32'(rdy[b]), 32'(e.rdy));
          chk($sformatf("busy_vec[bp%0d]", b), bv[b], e.bv);
          chk($sformatf("wb_err[bp%0d]", b), 32'(err[b]), 32'(e.err));
        end
      end
    end
  end

  initial begin
    stim_t s;
    model_reset();
    reset = 1'b0; rs1 = '0; rs2 = '0; use_rs1 = 1'b0; use_rs2 = 1'b0;
    issue_valid = 1'b0; issue_rd = '0; wb_valid = 1'b0; wb_rd = '0; wb_data = '0; flush = 1'b0;
    @(posedge clk); #1;
    s = idle(); s.rstn = 1'b0; step(s); step(s);

    // Mid-run reset after writing x5 with x6 pending.
    s = idle(); s.wv = 1; s.wrd = 5; s.wd = 32'hDEADBEEF; s.iv = 1; s.ird = 6; step(s);
    s = idle(); s.r1 = 5; s.r2 = 6; s.u2 = 1; s.ird = 6; step(s);
    s = idle(); s.rstn = 0; s.r1 = 5; s.ird = 6; step(s);
    s = idle(); s.r1 = 5; step(s);

    // Write x7 with a same-cycle read, then read again.
    s = idle(); s.wv = 1; s.wrd = 7; s.wd = 32'h0000_1234; s.r1 = 7; step(s);
    s = idle(); s.r1 = 7; step(s);

    // x0: write, issue, read all ignored.
    s = idle(); s.wv = 1; s.wrd = 0; s.wd = 32'hFFFFFFFF; s.iv = 1; s.ird = 0; s.u1 = 1; s.u2 = 1; step(s);
    s = idle(); s.u1 = 1; step(s);

    // WAW on x3.
    s = idle(); s.iv = 1; s.ird = 3; step(s);
    s = idle(); s.iv = 1; s.ird = 3; s.r1 = 3; s.u1 = 1; step(s);
    s = idle(); s.wv = 1; s.wrd = 3; s.wd = 32'h11; s.r1 = 3; s.u1 = 1; step(s);
    s = idle(); s.r1 = 3; s.u1 = 1; step(s);
    s = idle(); s.wv = 1; s.wrd = 3; s.wd = 32'h22; s.r1 = 3; s.u1 = 1; step(s);
    s = idle(); s.r1 = 3; s.u1 = 1; step(s);

    // Saturation on x9.
    repeat (3) begin s = idle(); s.iv = 1; s.ird = 9; step(s); end
    s = idle(); s.iv = 1; s.ird = 9; s.r1 = 9; step(s);
    s = idle(); s.iv = 1; s.ird = 9; s.wv = 1; s.wrd = 9; s.wd = 32'h9; step(s);
    s = idle(); s.ird = 9; s.r1 = 9; step(s);

    // Flush with x4 pending twice and same-cycle writeback; then stray wb.
    repeat (2) begin s = idle(); s.iv = 1; s.ird = 4; step(s); end
    s = idle(); s.fl = 1; s.wv = 1; s.wrd = 4; s.wd = 32'h55; step(s);
    s = idle(); s.r1 = 4; step(s);
    s = idle(); s.wv = 1; s.wrd = 4; s.wd = 32'h66; step(s);
    s = idle(); s.r1 = 4; step(s);
    s = idle(); step(s);

    // Random traffic concentrated on a few registers to build up hazards.
    for (int n = 0; n < 800; n++) begin
      s = idle();
      s.rstn = ($urandom_range(0, 249) != 0);
      s.r1 = $urandom_range(0, 7); s.r2 = $urandom_range(0, 7);
      s.u1 = $urandom_range(0, 1); s.u2 = $urandom_range(0, 1);
      s.iv = ($urandom_range(0, 1) == 1); s.ird = $urandom_range(0, 7);
      s.wv = ($urandom_range(0, 9) < 4); s.wrd = $urandom_range(0, 7);
      s.wd = $urandom();
      s.fl = ($urandom_range(0, 29) == 0);
      if ($urandom_range(0, 19) == 0) s.wrd = $urandom_range(0, NREGS - 1);
      step(s);
    end

    s = idle(); step(s);
    repeat (2) @(negedge clk);
    tests++;
    if (q.size() != 0) begin
      fails++;
      $display("FAIL drain got=%0d exp=0", q.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/regfile_scoreboard.md
Name: regfile_scoreboard

Overview:
- Parametrised successor to the processor's integer register file: XLEN x NREGS storage, two combinational read ports and one write port.
- Adds optional write-to-read bypass and a per-register pending-write scoreboard with saturating counters.
- Produces a stall/hazard signal for the pipelined core between decode (read/issue) and writeback.

Parameters:
- XLEN, 32, data width in bits
- NREGS, 32, register count; power of 2, >= 2
- AW, $clog2(NREGS), register index width (derived; do not override)
- MAX_PEND, 3, outstanding writes tracked per register (1..7); counter width CW = $clog2(MAX_PEND+1)
- BYPASS, 1, 1 = writeback data forwarded to same-cycle reads

Ports:
- clk  in  1  system clock, rising edge
- reset  in  1  asynchronous, active-low reset
- rs1, rs2  in  AW  read indices
- use_rs1, use_rs2  in  1  current instruction consumes rs1/rs2
- rd1_data, rd2_data  out  XLEN  read data
- rs1_busy, rs2_busy  out  1  source register has an outstanding write
- hazard  out  1  (use_rs1 & rs1_busy) | (use_rs2 & rs2_busy)
- issue_valid  in  1  decode issues an instruction writing issue_rd
- issue_rd  in  AW  destination of the issuing instruction
- issue_ready  out  1  issue accepted this cycle
- wb_valid  in  1  writeback strobe
- wb_rd  in  AW  writeback destination
- wb_data  in  XLEN  writeback data
- flush  in  1  synchronous; clears all pending counters
- busy_vec  out  NREGS  bit i = pend_cnt[i] != 0
- wb_err  out  1  registered one-cycle pulse: writeback to a register with pend_cnt 0 (non-x0)

Behaviour:
- Reset (reset low, asynchronous): all regs = 0, all pend_cnt = 0, wb_err = 0.
- Effect of reset on outputs: rd*_data = 0, busy/hazard = 0, busy_vec = 0, issue_ready = 1.
- Register 0 is hardwired zero:
  - reads return 0;
  - writes, issues and wb_err checks to index 0 are ignored;
  - never busy; issue_ready = 1 for issue_rd = 0.
- Write: on a clk rising edge with wb_valid && wb_rd != 0, regs[wb_rd] <= wb_data; visible to plain reads next cycle.
- Read: combinational.
  - BYPASS=1 and wb_valid && wb_rd == rsX && rsX != 0: rdX_data = wb_data.
  - Otherwise rdX_data = regs[rsX].
- Issue handshake:
  - issue_fire = issue_valid && issue_ready && issue_rd != 0.
  - issue_ready = 0 only when pend_cnt[issue_rd] == MAX_PEND and no writeback to issue_rd this cycle.
  - issue_ready is combinational and independent of issue_valid.
- Counter update per register r, at the clk edge:
  - flush: all counters <= 0. Flush has priority over issue and wb; wb data is still written.
  - Else inc = issue_fire && issue_rd == r; dec = wb_valid && wb_rd == r && pend_cnt[r] != 0.
  - inc && !dec: +1. dec && !inc: -1. Both: unchanged.
- Unexpected writeback: wb_valid to r != 0 with pend_cnt[r] == 0 and no same-cycle issue to r.
  - Data is written, counter stays 0.
  - wb_err = 1 for exactly the following cycle.
- Busy:
  - rsX_busy = pend_cnt[rsX] != 0 && rsX != 0.
  - Exception when BYPASS=1: rsX_busy = 0 if pend_cnt[rsX] == 1 && wb_valid && wb_rd == rsX (the final write is forwarded).
  - busy_vec uses raw counters, with no bypass adjustment.
- Issue and read of the same register in one cycle: busy reflects the pre-issue count, so the issuing instruction does not stall on itself.
- Reset asserted mid-operation: all state clears immediately; in-flight writebacks are lost.

Decomposition:
- Shared package regfile_pkg:
  - REG_ZERO constant (index 0);
  - typedef pend_cnt_t (CW bits);
  - default XLEN/NREGS constants shared with decode and writeback.
- One sub-module, pend_counter: single-register saturating up/down counter with inc, dec, clr inputs and cnt, nonzero, full outputs.
- Instantiate pend_counter NREGS-1 times via generate; register 0 has no counter.

Test Plan:
- Reset low mid-run after writing x5=0xDEADBEEF -> rd1_data(rs1=5) = 0 immediately; busy_vec = 0; issue_ready = 1.
- Write x7=0x0000_1234 with BYPASS=1, rs1=7 same cycle -> rd1_data = 0x1234 that cycle. With BYPASS=0 -> old value that cycle, 0x1234 next cycle.
- wb_valid, wb_rd=0, wb_data=0xFFFFFFFF; issue_rd=0 -> rd reads of x0 = 0; busy_vec[0] = 0; wb_err = 0.
- WAW sequence: issue x3, issue x3, wb x3 -> rs1_busy(3) = 1; second wb -> busy clears; with use_rs1=1, hazard = 1 then 0.
- Saturation: MAX_PEND=3, issue x9 three times -> issue_ready = 0 for issue_rd=9. Fourth issue plus same-cycle wb x9 -> issue_ready = 1, count stays 3.
- flush with pend_cnt[4]=2 and same-cycle wb x4=0x55 -> busy_vec = 0 next cycle, x4 = 0x55. Later wb x4 -> wb_err pulses high for exactly one cycle.
